// File: rtl/cpu_pkg.sv
// cpu_pkg: shared access-type and write-back-select encodings for the memory stage
package cpu_pkg;
    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {WD_ALU, WD_MEM, WD_PC4, WD_IMM} wd_sel_e;

    // Bytes touched by one access; unlisted encodings behave as words.
    function automatic logic [2:0] dm_size(input logic [2:0] t);
        return (t == DM_BYTE || t == DM_BYTE_U) ? 3'd1 :
               (t == DM_HALF || t == DM_HALF_U) ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/ex_mem_reg_if.sv
// ex_mem_reg_if: data-memory request bus (byte address, store data, access type, write strobe)
//   master drives the bus (pipeline register), slave observes it (memory)
interface ex_mem_reg_if #(parameter int DM_AW = 6, parameter int XLEN = 32);
    logic [DM_AW-1:0] dm_addr;
    logic [XLEN-1:0]  dm_din;
    logic [2:0]       dm_type;
    logic             dm_wr;

    modport master (output dm_addr, dm_din, dm_type, dm_wr);
    modport slave  (input  dm_addr, dm_din, dm_type, dm_wr);
endinterface

// File: rtl/mem_fault_chk.sv
// mem_fault_chk: combinational misalignment / out-of-range check for one data-memory access
//   addr, dm_type, access in; misalign, range_err, size (1/2/4 bytes) out
module mem_fault_chk
    import cpu_pkg::*;
#(
    parameter int DM_AW = 6,
    parameter int XLEN  = 32
) (
    input  logic [XLEN-1:0] addr,
    input  logic [2:0]      dm_type,
    input  logic            access,
    output logic            misalign,
    output logic            range_err,
    output logic [2:0]      size
);
    logic [DM_AW:0] last;

    assign size = dm_size(dm_type);
    // One extra bit catches a last byte that runs past the top of memory.
    assign last = {1'b0, addr[DM_AW-1:0]} + (DM_AW+1)'(size) - (DM_AW+1)'(1);

    always_comb begin
        misalign  = access & ((size == 3'd2) ? addr[0] : (size == 3'd4) ? |addr[1:0] : 1'b0);
        range_err = access & ((|addr[XLEN-1:DM_AW]) | last[DM_AW]);
    end
endmodule

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register driving the byte-addressed data memory
//   clk/rst, stall/flush from hazard unit, ex_* execute results, wb_* for store-data forwarding,
//   mem_* registered stage outputs, dm memory bus, misalign/range faults with fault_addr
module ex_mem_reg
    import cpu_pkg::*;
#(
    parameter int DM_AW = 6,
    parameter int XLEN  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               ex_valid,
    input  logic [XLEN-1:0]    ex_pc,
    input  logic [XLEN-1:0]    ex_alu_result,
    input  logic [XLEN-1:0]    ex_rs2_data,
    input  logic [4:0]         ex_rs2_addr,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    input  logic [2:0]         ex_dm_type,
    input  logic               ex_reg_write,
    input  logic [4:0]         ex_rd,
    input  logic [1:0]         ex_wd_sel,
    input  logic               wb_reg_write,
    input  logic [4:0]         wb_rd,
    input  logic [XLEN-1:0]    wb_wdata,
    output logic               mem_valid,
    output logic [XLEN-1:0]    mem_pc,
    output logic [XLEN-1:0]    mem_alu_result,
    output logic               mem_mem_read,
    output logic               mem_reg_write,
    output logic [4:0]         mem_rd,
    output logic [1:0]         mem_wd_sel,
    output logic               misalign_exc,
    output logic               range_exc,
    output logic [XLEN-1:0]    fault_addr,
    ex_mem_reg_if.master       dm
);
    logic            access, fwd, hfwd, mis, rng, mem_write_q, unused_sz;
    logic [4:0]      rs2_q;
    logic [2:0]      type_q, sz;
    logic [XLEN-1:0] din_q;

    mem_fault_chk #(.DM_AW(DM_AW), .XLEN(XLEN)) u_chk (
        .addr      (ex_alu_result),
        .dm_type   (ex_dm_type),
        .access    (access),
        .misalign  (mis),
        .range_err (rng),
        .size      (sz)
    );

    assign unused_sz = ^sz;
    assign access    = ex_valid & (ex_mem_read | ex_mem_write);
    assign fwd       = ex_mem_write & wb_reg_write & (wb_rd != 5'd0) & (wb_rd == ex_rs2_addr);
    // A stalled store keeps picking up the newest WB value of its source register.
    assign hfwd      = mem_valid & mem_write_q & wb_reg_write & (wb_rd != 5'd0) & (wb_rd == rs2_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid      <= 1'b0;
            mem_pc         <= '0;
            mem_alu_result <= '0;
            mem_mem_read   <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_rd         <= '0;
            mem_wd_sel     <= WD_ALU;
            din_q          <= '0;
            type_q         <= DM_WORD;
            rs2_q          <= '0;
            misalign_exc   <= 1'b0;
            range_exc      <= 1'b0;
            fault_addr     <= '0;
        end else if (flush || (!stall && !ex_valid)) begin
            // Bubble: control and faults cleared, data fields left as they were.
            mem_valid     <= 1'b0;
            mem_mem_read  <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_wd_sel    <= WD_ALU;
            type_q        <= DM_WORD;
            misalign_exc  <= 1'b0;
            range_exc     <= 1'b0;
        end else if (stall) begin
            if (hfwd) din_q <= wb_wdata;
        end else begin
            mem_valid      <= 1'b1;
            mem_pc         <= ex_pc;
            mem_alu_result <= ex_alu_result;
            mem_mem_read   <= ex_mem_read;
            mem_write_q    <= ex_mem_write;
            mem_reg_write  <= ex_reg_write & ~(mis | rng);
            mem_rd         <= ex_rd;
            mem_wd_sel     <= ex_wd_sel;
            din_q          <= fwd ? wb_wdata : ex_rs2_data;
            type_q         <= access ? ex_dm_type : DM_WORD;
            rs2_q          <= ex_rs2_addr;
            misalign_exc   <= mis;
            range_exc      <= rng;
            if (mis | rng) fault_addr <= ex_alu_result;
        end
    end

    assign dm.dm_addr = mem_alu_result[DM_AW-1:0];
    assign dm.dm_din  = din_q;
    assign dm.dm_type = type_q;
    assign dm.dm_wr   = mem_valid & mem_write_q & ~misalign_exc & ~range_exc;
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: directed and randomized checks of ex_mem_reg against a behavioural model
module tb_ex_mem_reg;
    logic        clk = 1'b0, rst, stall, flush;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, wb_reg_write;
    logic [31:0] ex_pc, ex_alu_result, ex_rs2_data, wb_wdata;
    logic [4:0]  ex_rs2_addr, ex_rd, wb_rd;
    logic [2:0]  ex_dm_type;
    logic [1:0]  ex_wd_sel;
    logic        mem_valid, mem_mem_read, mem_reg_write, misalign_exc, range_exc;
    logic [31:0] mem_pc, mem_alu_result, fault_addr;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wd_sel;
    int          total = 0, bad = 0;

    ex_mem_reg_if #(.DM_AW(6), .XLEN(32)) dm ();

    ex_mem_reg #(.DM_AW(6), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_result(ex_alu_result),
        .ex_rs2_data(ex_rs2_data), .ex_rs2_addr(ex_rs2_addr),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_dm_type(ex_dm_type),
        .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .ex_wd_sel(ex_wd_sel),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_alu_result(mem_alu_result),
        .mem_mem_read(mem_mem_read), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .mem_wd_sel(mem_wd_sel), .misalign_exc(misalign_exc), .range_exc(range_exc),
        .fault_addr(fault_addr), .dm(dm)
    );

    always #5 clk = ~clk;

    // Expected MEM-stage contents
    logic        e_valid, e_rdf, e_wrf, e_rw, e_mis, e_rng;
    logic [31:0] e_pc, e_alu, e_din, e_fa;
    logic [4:0]  e_rd, e_rs2;
    logic [1:0]  e_wd;
    logic [2:0]  e_type;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int bytes_of(input logic [2:0] t);
        if (t == 3'd3 || t == 3'd4) return 1;
        if (t == 3'd1 || t == 3'd2) return 2;
        return 4;
    endfunction

    task automatic model_step();
        int  sz;
        bit  acc, mis, rng;
        if (rst) begin
            {e_valid, e_rdf, e_wrf, e_rw, e_mis, e_rng} = '0;
            {e_pc, e_alu, e_din, e_fa} = '0;
            e_rd = 0; e_rs2 = 0; e_wd = 0; e_type = 0;
        end else if (flush || (!stall && !ex_valid)) begin
            {e_valid, e_rdf, e_wrf, e_rw, e_mis, e_rng} = '0;
            e_wd = 0; e_type = 0;
        end else if (stall) begin
            if (e_valid && e_wrf && wb_reg_write && wb_rd != 0 && wb_rd == e_rs2) e_din = wb_wdata;
        end else begin
            sz  = bytes_of(ex_dm_type);
            acc = ex_mem_read || ex_mem_write;
            mis = acc && (ex_alu_result % sz != 0);
            rng = acc && (ex_alu_result >= 64 || (ex_alu_result % 64) + sz > 64);
            e_valid = 1; e_pc = ex_pc; e_alu = ex_alu_result;
            e_rdf = ex_mem_read; e_wrf = ex_mem_write;
            e_rw = ex_reg_write && !mis && !rng;
            e_rd = ex_rd; e_wd = ex_wd_sel; e_rs2 = ex_rs2_addr;
            e_din = (ex_mem_write && wb_reg_write && wb_rd != 0 && wb_rd == ex_rs2_addr) ? wb_wdata : ex_rs2_data;
            e_type = acc ? ex_dm_type : 3'd0;
            e_mis = mis; e_rng = rng;
            if (mis || rng) e_fa = ex_alu_result;
        end
    endtask

    task automatic check_all();
        check("valid", mem_valid, e_valid);
        check("pc", mem_pc, e_pc);
        check("alu", mem_alu_result, e_alu);
        check("mem_read", mem_mem_read, e_rdf);
        check("reg_write", mem_reg_write, e_rw);
        check("rd", mem_rd, e_rd);
        check("wd_sel", mem_wd_sel, e_wd);
        check("dm_addr", dm.dm_addr, e_alu % 64);
        check("dm_din", dm.dm_din, e_din);
        check("dm_type", dm.dm_type, e_type);
        check("dm_wr", dm.dm_wr, e_valid && e_wrf && !e_mis && !e_rng);
        check("misalign", misalign_exc, e_mis);
        check("range", range_exc, e_rng);
        check("fault_addr", fault_addr, e_fa);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        rst = 0; stall = 0; flush = 0; ex_valid = 0; ex_pc = 0; ex_alu_result = 0;
        ex_rs2_data = 0; ex_rs2_addr = 0; ex_mem_read = 0; ex_mem_write = 0; ex_dm_type = 0;
        ex_reg_write = 0; ex_rd = 0; ex_wd_sel = 0; wb_reg_write = 0; wb_rd = 0; wb_wdata = 0;
    endtask

    task automatic op(input logic rd_, input logic wr_, input logic [2:0] t, input logic [31:0] a);
        ex_valid = 1; ex_mem_read = rd_; ex_mem_write = wr_; ex_dm_type = t;
        ex_alu_result = a; ex_reg_write = rd_ | ~wr_; ex_rd = 5'd9; ex_pc = ex_pc + 4;
    endtask

    task automatic randomize_inputs();
        logic [2:0] types [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        rst   = ($urandom_range(0, 99) < 3);
        stall = ($urandom_range(0, 3) == 0);
        flush = ($urandom_range(0, 9) == 0);
        ex_valid = ($urandom_range(0, 7) != 0);
        ex_pc = $urandom;
        ex_alu_result = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 70));
        ex_rs2_data = $urandom; ex_rs2_addr = 5'($urandom_range(0, 7));
        ex_mem_read = $urandom_range(0, 1); ex_mem_write = $urandom_range(0, 1);
        ex_dm_type = types[$urandom_range(0, 4)];
        ex_reg_write = $urandom_range(0, 1); ex_rd = 5'($urandom); ex_wd_sel = 2'($urandom);
        wb_reg_write = $urandom_range(0, 1); wb_rd = 5'($urandom_range(0, 7)); wb_wdata = $urandom;
    endtask

    initial begin
        idle();
        rst = 1;
        @(negedge clk);
        tick();
        rst = 0;
        for (int i = 0; i < 20; i++) begin randomize_inputs(); rst = 0; tick(); end
        idle(); rst = 1; op(0, 1, 3'd0, 32'h8); tick(); tick();
        check("rst_valid", mem_valid, 0); check("rst_type", dm.dm_type, 0);
        check("rst_wr", dm.dm_wr, 0); check("rst_fa", fault_addr, 0);
        rst = 0; op(0, 1, 3'd0, 32'h8); tick();
        check("sw8_wr", dm.dm_wr, 1); check("sw8_addr", dm.dm_addr, 6'h08);

        op(0, 1, 3'd0, 32'h10); ex_rs2_addr = 5; ex_rs2_data = 32'h1111_1111;
        wb_reg_write = 1; wb_rd = 5; wb_wdata = 32'hDEAD_BEEF; tick();
        check("fwd_hit", dm.dm_din, 32'hDEAD_BEEF);
        wb_rd = 0; op(0, 1, 3'd0, 32'h10); tick();
        check("fwd_x0", dm.dm_din, 32'h1111_1111);

        wb_reg_write = 0; op(0, 1, 3'd0, 32'h20); ex_rs2_addr = 7; ex_rs2_data = 32'h1234; tick();
        stall = 1; ex_pc = 32'hFFFF_0000; ex_alu_result = 32'h4;
        tick();
        wb_reg_write = 1; wb_rd = 7; wb_wdata = 32'hCAFE_0001; tick();
        wb_reg_write = 0; tick();
        check("stall_din", dm.dm_din, 32'hCAFE_0001); check("stall_addr", dm.dm_addr, 6'h20);
        check("stall_wr", dm.dm_wr, 1);
        flush = 1; tick();
        check("sf_wr", dm.dm_wr, 0); check("sf_valid", mem_valid, 0);
        flush = 0; stall = 0;

        op(0, 1, 3'd1, 32'h3); tick();
        check("sh3_mis", misalign_exc, 1); check("sh3_wr", dm.dm_wr, 0); check("sh3_fa", fault_addr, 3);
        op(1, 0, 3'd0, 32'h6); tick(); check("lw6_mis", misalign_exc, 1);
        check("lw6_rw", mem_reg_write, 0);
        op(1, 0, 3'd3, 32'h7); tick(); check("lb7_mis", misalign_exc, 0); check("lb7_rng", range_exc, 0);
        op(1, 0, 3'd0, 32'h3C); tick(); check("lw3c_ok", misalign_exc | range_exc, 0);
        op(1, 0, 3'd0, 32'h3E); tick(); check("lw3e_mis", misalign_exc, 1);
        op(0, 1, 3'd0, 32'h40); tick(); check("sw40_rng", range_exc, 1); check("sw40_wr", dm.dm_wr, 0);
        check("sw40_valid", mem_valid, 1);
        op(1, 0, 3'd4, 32'h3F); tick(); check("lbu3f_ok", misalign_exc | range_exc, 0);
        check("lbu3f_rw", mem_reg_write, 1);
        op(1, 0, 3'd1, 32'h3F); tick(); check("lh3f_mis", misalign_exc, 1);
        op(0, 0, 3'd3, 32'h3F); tick();
        check("add_type", dm.dm_type, 0); check("add_wr", dm.dm_wr, 0);
        check("add_rw", mem_reg_write, 1); check("add_exc", misalign_exc | range_exc, 0);

        op(0, 1, 3'd0, 32'h0); tick(); stall = 1; tick(); rst = 1; tick();
        check("rst_stall_wr", dm.dm_wr, 0);
        idle();

        for (int i = 0; i < 3000; i++) begin randomize_inputs(); tick(); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
